// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared state encoding and defaults for the req/ack receive controller
package cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELIVER = 2'd1,
        ST_ACK     = 2'd2
    } cdc_state_e;

    localparam int unsigned CDC_NUM_STAGES_DEF = 2;

endpackage

// File: rtl/bit_sync_sr.sv
// rtl/bit_sync_sr.sv - single-bit flop-chain synchroniser with synchronous active-high reset
module bit_sync_sr #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[NUM_STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_rx_handshake_ctrl.sv
// rtl/cdc_rx_handshake_ctrl.sv - 4-phase req/ack receiver: syncs req only, captures the held bus, hands it off on valid/ready
module cdc_rx_handshake_ctrl
    import cdc_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_STAGES = CDC_NUM_STAGES_DEF,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_req,
    input  logic [BUS_WIDTH-1:0] src_data,
    output logic                 src_ack,
    output logic [BUS_WIDTH-1:0] dst_data,
    output logic                 dst_valid,
    input  logic                 dst_ready,
    input  logic                 err_clr,
    output logic                 proto_err,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic                 busy
);

    logic                 req_s;
    cdc_state_e           state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 err_set;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    bit_sync_sr #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (src_req),
        .q_o  (req_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // src_data is only trusted on the IDLE->DELIVER edge, once req_s proves it has settled
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
                if (req_s) begin
                    data_d  = src_data;
                    valid_d = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (!req_s) begin
                    err_set = 1'b1;
                end
                if (valid_q && dst_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    assign src_ack    = ack_q;
    assign dst_valid  = valid_q;
    assign dst_data   = data_q;
    assign proto_err  = err_q;
    assign xfer_count = cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/cdc_rx_handshake_ctrl.md
Name: cdc_rx_handshake_ctrl

Overview:
Receive-side controller for a 4-phase req/ack bus transfer arriving from a foreign clock domain.
- Synchronises only the request line through an NUM_STAGES flop chain.
- Captures the quasi-static data bus once the request is settled, presents it on a valid/ready interface and returns an acknowledge.
- Sits between the async command path and the local command decoder. It replaces per-bit bus synchronisation, so multi-bit data is never skew-sampled.

Parameters:
BUS_WIDTH, 8, width of transferred data word
NUM_STAGES, 2, request synchroniser depth (legal range 2..4)
CNT_WIDTH, 16, width of completed-transfer counter

Ports:
clk  input  1  destination-domain clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
src_req  input  1  async request from source domain; level, 4-phase
src_data  input  BUS_WIDTH  async data; source holds it stable from before src_req rises until src_ack seen high
src_ack  output  1  registered acknowledge to source domain
dst_data  output  BUS_WIDTH  captured word
dst_valid  output  1  captured word available
dst_ready  input  1  consumer accepts dst_data when dst_valid && dst_ready
err_clr  input  1  clears proto_err
proto_err  output  1  sticky: src_req withdrawn before ack
xfer_count  output  CNT_WIDTH  completed handshakes, wraps modulo 2^CNT_WIDTH
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sync chain, src_ack, dst_valid, proto_err, xfer_count, dst_data all 0.
  - rst dominates every other input. A mid-transfer reset abandons the transfer.
  - If src_req is still high after reset, a fresh transfer begins: it is re-captured and delivered again.
- req_s: src_req delayed through NUM_STAGES flops. It is the only signal derived from src_req. src_data is never synchronised and is sampled only in IDLE->DELIVER.
- States: IDLE, DELIVER, ACK.
- IDLE:
  - src_ack=0, dst_valid=0.
  - If req_s=1: dst_data<=src_data, dst_valid<=1, go to DELIVER.
  - Latency: src_req rising before edge k gives req_s high after edge k+NUM_STAGES-1 and dst_valid high after edge k+NUM_STAGES.
- DELIVER:
  - dst_valid held 1 and dst_data held stable until dst_valid&&dst_ready.
  - On that handshake edge: dst_valid<=0, src_ack<=1, xfer_count<=xfer_count+1, go to ACK.
  - If req_s=0 on any DELIVER cycle: proto_err<=1. Delivery still completes normally.
- ACK:
  - src_ack held 1 while req_s=1.
  - When req_s=0: src_ack<=0, go to IDLE.
  - No new capture can occur until the state returns to IDLE, so a stuck-high src_req never yields duplicates.
- Back-to-back transfers: minimum req_s-low-to-next-capture spacing is one IDLE cycle. A new req_s rising observed in that cycle is captured.
- proto_err: set has priority over err_clr in the same cycle. err_clr clears it otherwise.
- xfer_count wraps from all-ones to 0 silently.
- busy is combinational from state. All other outputs are registered.

Decomposition:
- Shared package cdc_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_DELIVER=2'd1, ST_ACK=2'd2
  - default NUM_STAGES=2 constant
- One sub-module: bit_sync_sr. It is a single-bit NUM_STAGES flop chain with synchronous active-high reset, instantiated for src_req. It is reusable for other single-bit control crossings.
- FSM, capture register and counter stay in the top module.

Test Plan:
All scenarios use BUS_WIDTH=8, NUM_STAGES=2.
1. Basic transfer: src_data=8'hA5, src_req rises before edge 0, dst_ready=1 -> dst_valid=1 after edge 2, dst_data=8'hA5; src_ack=1 after edge 3; drop src_req -> src_ack=0 two edges later; xfer_count=1; proto_err=0.
2. Backpressure: dst_ready=0 for 10 cycles with data 8'h3C -> dst_valid and dst_data=8'h3C held for all 10 cycles; src_ack stays 0 until the cycle after dst_ready=1.
3. Stuck request: src_req held high 50 cycles after ack -> exactly one dst_valid pulse and xfer_count=1; src_data changed to 8'hFF after ack is never delivered.
4. Early withdrawal: src_req drops while in DELIVER with dst_ready=0 -> proto_err=1; word still delivered on dst_ready; src_ack pulses one cycle then 0. err_clr=1 clears proto_err, but proto_err stays 1 if err_clr coincides with a new violation.
5. Reset mid-transfer: rst=1 during ACK -> all outputs 0 next edge, busy=0. With src_req still high, the word is re-delivered NUM_STAGES+1 cycles after rst drops.
6. Back-to-back and wrap: 65537 sequential transfers with data incrementing from 8'h00 -> every word delivered in order and xfer_count=1 at the end.
